romulus_pdo_packer: RTL and testbench

Byte-to-word collector on the output side of the byte-serial Romulus state datapath. It accepts the 8-bit `pdo` stream that the state emits, one byte per shift cycle. It packs valid bytes big-endian into 32-bit words for the public data-out bus, which uses a valid/ready handshake. In decryption it performs the tag check: the received tag is fed as `pdi`, so `pdo = G(S) ^ tag` is all-zero on a match.

---
 rtl/romulus_pkg.sv | 19 +
 rtl/romulus_pdo_packer_if.sv | 20 ++
 rtl/romulus_out_reg.sv | 51 +++++
 rtl/romulus_pdo_packer.sv | 173 +++++++++++++++++
 tb/tb_romulus_pdo_packer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/romulus_pkg.sv
// rtl/romulus_pkg.sv - shared kind encodings, block size and FSM states for the Romulus output packer
package romulus_pkg;

   localparam logic [4:0] TAG_BYTES = 5'd16;

   typedef enum logic [1:0] {
      KIND_AD     = 2'b00,
      KIND_DATA   = 2'b01,
      KIND_TAG    = 2'b10,
      KIND_VERIFY = 2'b11
   } kind_e;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      DRAIN = 2'b10
   } state_e;

endpackage

// File: rtl/romulus_pdo_packer_if.sv
// rtl/romulus_pdo_packer_if.sv - byte input stream and word output handshake of the packer
interface romulus_pdo_packer_if;
   logic [7:0]  pdo;
   logic        pdo_vld;
   logic        pdo_rdy;
   logic [31:0] do_data;
   logic        do_valid;
   logic        do_ready;
   logic        do_last;

   modport master (
      output pdo, pdo_vld, do_ready,
      input  pdo_rdy, do_data, do_valid, do_last
   );

   modport slave (
      input  pdo, pdo_vld, do_ready,
      output pdo_rdy, do_data, do_valid, do_last
   );
endinterface

// File: rtl/romulus_out_reg.sv
// rtl/romulus_out_reg.sv - single-entry valid/ready register slice for the 32-bit word and last flag
module romulus_out_reg (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] in_data,
   input  logic        in_last,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        out_valid,
   input  logic        out_ready
);

   logic [31:0] data_q, data_d;
   logic        last_q, last_d;
   logic        valid_q, valid_d;

   // Accepts when empty or when the held word leaves at this same edge.
   assign in_ready = !valid_q || out_ready;

   always_comb begin
      data_d  = data_q;
      last_d  = last_q;
      valid_d = valid_q;
      if (in_ready) begin
         valid_d = in_valid;
         if (in_valid) begin
            data_d = in_data;
            last_d = in_last;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= 32'h0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         last_q  <= last_d;
         valid_q <= valid_d;
      end
   end

   assign out_data  = data_q;
   assign out_last  = last_q;
   assign out_valid = valid_q;

endmodule

// File: rtl/romulus_pdo_packer.sv
// rtl/romulus_pdo_packer.sv - packs state output bytes big-endian into 32-bit words and checks tags
module romulus_pdo_packer
   import romulus_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   romulus_pdo_packer_if.slave  bus,
   input  logic                 blk_start,
   input  logic [1:0]           blk_kind,
   input  logic [4:0]           blk_len,
   input  logic                 blk_last,
   output logic                 busy,
   output logic                 auth_valid,
   output logic                 auth_fail
);

   state_e      state_q, state_d;
   kind_e       kind_q, kind_d;
   logic [4:0]  len_q, len_d;
   logic        last_q, last_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  acc_q, acc_d;
   logic [31:0] asm_q, asm_d;
   logic        wpend_q, wpend_d;
   logic        wlast_q, wlast_d;
   logic        auth_valid_q, auth_valid_d;
   logic        auth_fail_q, auth_fail_d;

   logic [4:0]  len_eff;
   logic        word_kind;
   logic        accept;
   logic        in_len;
   logic        final_byte;
   logic        take;
   logic        word_done;
   logic        blk_end;
   logic [31:0] asm_nxt;
   logic        push_valid;
   logic [31:0] push_data;
   logic        push_last;
   logic        push_ready;
   logic        out_valid;

   assign len_eff    = (kind_q == KIND_DATA) ? len_q : TAG_BYTES;
   assign word_kind  = (kind_q == KIND_DATA) || (kind_q == KIND_TAG);
   assign accept     = (state_q == RUN) && !wpend_q && bus.pdo_vld;
   assign in_len     = ({1'b0, cnt_q} < len_eff);
   assign final_byte = ({1'b0, cnt_q} == (len_eff - 5'd1));
   assign take       = accept && word_kind && in_len;
   assign word_done  = take && ((cnt_q[1:0] == 2'b11) || final_byte);
   assign blk_end    = accept && (cnt_q == 4'(TAG_BYTES - 5'd1));

   // Byte slot follows the byte index, so a short final word is zero-padded for free.
   always_comb begin
      asm_nxt = asm_q;
      case (cnt_q[1:0])
         2'd0: asm_nxt = {bus.pdo, 24'h0};
         2'd1: asm_nxt = {asm_q[31:24], bus.pdo, 16'h0};
         2'd2: asm_nxt = {asm_q[31:16], bus.pdo, 8'h0};
         default: asm_nxt = {asm_q[31:8], bus.pdo};
      endcase
   end

   // A waiting word always has priority; no new byte can complete one meanwhile.
   assign push_valid = wpend_q || word_done;
   assign push_data  = wpend_q ? asm_q : asm_nxt;
   assign push_last  = wpend_q ? wlast_q : (last_q && final_byte);

   romulus_out_reg u_out_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (push_data),
      .in_last   (push_last),
      .in_valid  (push_valid),
      .in_ready  (push_ready),
      .out_data  (bus.do_data),
      .out_last  (bus.do_last),
      .out_valid (out_valid),
      .out_ready (bus.do_ready)
   );

   always_comb begin
      state_d      = state_q;
      kind_d       = kind_q;
      len_d        = len_q;
      last_d       = last_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      asm_d        = take ? asm_nxt : asm_q;
      wpend_d      = wpend_q;
      wlast_d      = wlast_q;
      auth_valid_d = 1'b0;
      auth_fail_d  = 1'b0;

      if (wpend_q && push_ready) begin
         wpend_d = 1'b0;
      end else if (word_done && !push_ready) begin
         wpend_d = 1'b1;
         wlast_d = last_q && final_byte;
      end

      if (accept && (kind_q == KIND_VERIFY)) begin
         acc_d = acc_q | bus.pdo;
      end

      case (state_q)
         IDLE: begin
            if (blk_start) begin
               kind_d  = kind_e'(blk_kind);
               len_d   = blk_len;
               last_d  = blk_last;
               cnt_d   = 4'h0;
               acc_d   = 8'h0;
               asm_d   = 32'h0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (accept) begin
               cnt_d = cnt_q + 4'h1;
            end
            if (blk_end) begin
               state_d = word_kind ? DRAIN : IDLE;
               if (kind_q == KIND_VERIFY) begin
                  auth_valid_d = 1'b1;
                  auth_fail_d  = ((acc_q | bus.pdo) != 8'h0);
               end
            end
         end
         DRAIN: begin
            if (!wpend_q && !out_valid) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         kind_q       <= KIND_AD;
         len_q        <= 5'h0;
         last_q       <= 1'b0;
         cnt_q        <= 4'h0;
         acc_q        <= 8'h0;
         asm_q        <= 32'h0;
         wpend_q      <= 1'b0;
         wlast_q      <= 1'b0;
         auth_valid_q <= 1'b0;
         auth_fail_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         kind_q       <= kind_d;
         len_q        <= len_d;
         last_q       <= last_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         asm_q        <= asm_d;
         wpend_q      <= wpend_d;
         wlast_q      <= wlast_d;
         auth_valid_q <= auth_valid_d;
         auth_fail_q  <= auth_fail_d;
      end
   end

   assign bus.pdo_rdy  = (state_q == RUN) && !wpend_q;
   assign bus.do_valid = out_valid;
   assign busy         = (state_q != IDLE);
   assign auth_valid   = auth_valid_q;
   assign auth_fail    = auth_fail_q;

endmodule

// File: tb/tb_romulus_pdo_packer.sv
// tb/tb_romulus_pdo_packer.sv - directed scoreboard bench for romulus_pdo_packer
module tb_romulus_pdo_packer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   romulus_pdo_packer_if bus ();

   logic       blk_start;
   logic [1:0] blk_kind;
   logic [4:0] blk_len;
   logic       blk_last;
   logic       busy;
   logic       auth_valid;
   logic       auth_fail;

   romulus_pdo_packer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .blk_start  (blk_start),
      .blk_kind   (blk_kind),
      .blk_len    (blk_len),
      .blk_last   (blk_last),
      .busy       (busy),
      .auth_valid (auth_valid),
      .auth_fail  (auth_fail)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [32:0] exp_w[$];
   logic        exp_a[$];
   logic [7:0]  vec[16];
   logic        hold_prev = 1'b0;
   logic [32:0] prev_out = '0;
   int          stall;

   task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_idle();
      int g = 0;
      @(negedge clk);
      while (busy && g < 300) begin
         @(negedge clk);
         g++;
      end
      if (busy) begin
         n_tests++;
         n_fail++;
         $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", g);
      end
   endtask

   // Drives one block; stall_idx is the first byte that waited on pdo_rdy (16 when none did).
   task automatic send_block(input logic [1:0] kind, input logic [4:0] len, input logic last,
                             input int nbytes, output int stall_idx);
      logic acc;
      int   guard;
      stall_idx = 16;
      wait_idle();
      @(posedge clk); #1;
      blk_start = 1'b1;
      blk_kind  = kind;
      blk_len   = len;
      blk_last  = last;
      @(posedge clk); #1;
      blk_start = 1'b0;
      for (int i = 0; i < nbytes; i++) begin
         bus.pdo     = vec[i];
         bus.pdo_vld = 1'b1;
         acc   = 1'b0;
         guard = 0;
         while (!acc) begin
            @(negedge clk);
            acc = bus.pdo_rdy;
            if (!acc && stall_idx == 16) stall_idx = i;
            guard++;
            if (guard > 200) begin
               n_tests++;
               n_fail++;
               $display("FAIL byte_timeout: byte %0d pdo_rdy 0, expected 1", i);
               bus.pdo_vld = 1'b0;
               return;
            end
            @(posedge clk); #1;
         end
      end
      bus.pdo_vld = 1'b0;
      if (kind == 2'b11 && nbytes == 16) begin
         @(negedge clk);
         check("auth_pulse_timing", {31'h0, auth_valid, busy}, 33'h2);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pdo_rdy"},    bus.pdo_rdy,  0);
      check({tag, "_busy"},       busy,         0);
      check({tag, "_do_valid"},   bus.do_valid, 0);
      check({tag, "_do_data"},    bus.do_data,  0);
      check({tag, "_do_last"},    bus.do_last,  0);
      check({tag, "_auth_valid"}, auth_valid,   0);
      check({tag, "_auth_fail"},  auth_fail,    0);
   endtask

   initial begin
      logic [32:0] e;
      logic        ea;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (hold_prev)
               check("do_hold_stable", {bus.do_last, bus.do_data}, prev_out);
            if (bus.do_valid && bus.do_ready) begin
               if (exp_w.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL do_unexpected: got %h, expected no word", {bus.do_last, bus.do_data});
               end else begin
                  e = exp_w.pop_front();
                  check("do_word", {bus.do_last, bus.do_data}, e);
               end
            end
            if (auth_valid) begin
               if (exp_a.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL auth_unexpected: got auth_fail=%0b, expected no pulse", auth_fail);
               end else begin
                  ea = exp_a.pop_front();
                  check("auth_fail", auth_fail, ea);
               end
            end
            hold_prev = bus.do_valid && !bus.do_ready;
            prev_out  = {bus.do_last, bus.do_data};
         end else begin
            hold_prev = 1'b0;
         end
      end
   end

   initial begin
      blk_start    = 1'b0;
      blk_kind     = 2'b00;
      blk_len      = 5'd0;
      blk_last     = 1'b0;
      bus.pdo      = 8'h00;
      bus.pdo_vld  = 1'b0;
      bus.do_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Full data block
      for (int i = 0; i < 16; i++) vec[i] = 8'(i);
      exp_w.push_back({1'b0, 32'h00010203});
      exp_w.push_back({1'b0, 32'h04050607});
      exp_w.push_back({1'b0, 32'h08090A0B});
      exp_w.push_back({1'b1, 32'h0C0D0E0F});
      send_block(2'b01, 5'd16, 1'b1, 16, stall);
      check("full_no_stall", 33'(stall), 33'd16);

      // Partial data block, len 6
      for (int i = 0; i < 16; i++) vec[i] = 8'(8'hAA + i);
      exp_w.push_back({1'b0, 32'hAAABACAD});
      exp_w.push_back({1'b1, 32'hAEAF0000});
      send_block(2'b01, 5'd6, 1'b1, 16, stall);
      check("partial_no_stall", 33'(stall), 33'd16);

      // Verify match then mismatch
      for (int i = 0; i < 16; i++) vec[i] = 8'h00;
      exp_a.push_back(1'b0);
      send_block(2'b11, 5'd0, 1'b0, 16, stall);
      vec[9] = 8'h01;
      exp_a.push_back(1'b1);
      send_block(2'b11, 5'd0, 1'b0, 16, stall);

      // Tag out under backpressure
      for (int i = 0; i < 16; i++) vec[i] = 8'(8'h10 + i);
      exp_w.push_back({1'b0, 32'h10111213});
      exp_w.push_back({1'b0, 32'h14151617});
      exp_w.push_back({1'b0, 32'h18191A1B});
      exp_w.push_back({1'b1, 32'h1C1D1E1F});
      bus.do_ready = 1'b0;
      fork
         begin
            repeat (11) @(posedge clk);
            #1;
            bus.do_ready = 1'b1;
         end
      join_none
      send_block(2'b10, 5'd3, 1'b1, 16, stall);
      check("bp_stall_after_byte7", 33'(stall), 33'd8);
      wait_idle();
      repeat (4) @(negedge clk);
      check("words_left", 33'(exp_w.size()), 33'd0);
      check("auth_left", 33'(exp_a.size()), 33'd0);

      // Reset in the middle of a verify block
      for (int i = 0; i < 16; i++) vec[i] = 8'h5A;
      send_block(2'b11, 5'd0, 1'b0, 6, stall);
      rst_n = 1'b0;
      #1;
      check_all_zero("midreset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send_block(2'b00, 5'd0, 1'b1, 16, stall);
      wait_idle();
      check("ad_busy_done", busy, 0);
      repeat (6) @(negedge clk);
      check("ad_no_valid", bus.do_valid, 0);
      check("final_words_left", 33'(exp_w.size()), 33'd0);
      check("final_auth_left", 33'(exp_a.size()), 33'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running, expected finish");
      $fatal(1, "timeout");
   end

endmodule
